// File: rtl/gpu_pkg.sv
// gpu_pkg: types and constants shared by the GPU frame-control blocks.
//   seq_state_t      - render_sequencer state encoding
//   ZB_CLEAR_VALUE   - z-buffer clear word (all ones = farthest depth);
//                      users take the low ZB_DATA_W bits
//   SCREEN_W/H       - default screen size, giving the default z-buffer depth
package gpu_pkg;

    localparam int unsigned SCREEN_W         = 320;
    localparam int unsigned SCREEN_H         = 240;
    localparam int unsigned ZB_DEPTH_DEFAULT = SCREEN_W * SCREEN_H;

    localparam logic [31:0] ZB_CLEAR_VALUE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_CLEAR = 3'd2,
        ST_SETUP = 3'd3,
        ST_START = 3'd4,
        ST_WAIT  = 3'd5,
        ST_NEXT  = 3'd6,
        ST_SWAP  = 3'd7
    } seq_state_t;

    // Every state outside the key-handling pair counts as busy.
    function automatic logic is_busy_state(input seq_state_t s);
        return (s != ST_IDLE) && (s != ST_ARMED);
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// key_debouncer: counts consecutive cycles a key is held while enabled and,
// on release, emits a one-cycle pulse saying whether the hold was long enough.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_enable       : counting allowed (counter is cleared while low)
//   i_key          : active-high key level
//   o_trigger      : one-cycle pulse, key released after >= HOLD_CYCLES cycles
//   o_reject       : one-cycle pulse, key released after a shorter hold
module key_debouncer #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_key,
    output logic o_trigger,
    output logic o_reject
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic             r_trigger;
    logic             r_reject;
    logic             w_release;

    // A release is only meaningful if at least one held cycle was counted.
    assign w_release = i_enable && !i_key && (r_cnt != {CNT_W{1'b0}});

    // Saturating hold counter and registered release verdicts.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= {CNT_W{1'b0}};
            r_trigger <= 1'b0;
            r_reject  <= 1'b0;
        end else begin
            if (i_enable && i_key) begin
                if (r_cnt != HOLD_MAX) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= {CNT_W{1'b0}};
            end
            r_trigger <= w_release && (r_cnt == HOLD_MAX);
            r_reject  <= w_release && (r_cnt != HOLD_MAX);
        end
    end

    assign o_trigger = r_trigger;
    assign o_reject  = r_reject;

endmodule

// File: rtl/render_sequencer.sv
// render_sequencer: frame-level GPU controller. A debounced key press (or
// continuous mode) clears the z-buffer, issues one rasterizer start per
// triangle, then swaps front/back buffers on a vsync falling edge.
// Ports:
//   MAX10_CLK1_50 : clock;  reset : synchronous active-high
//   user_key      : trigger key (active high), ignored while busy
//   continuous    : restart a frame after each swap (sampled at swap)
//   vga_vs        : vertical sync, active low
//   raster_done   : rasterizer completion level (sampled only in WAIT)
//   raster_start  : one-cycle rasterizer start pulse
//   tri_idx       : current triangle index
//   zb_clr_we/addr/data : z-buffer clear write port
//   buffer_select : displayed frame buffer
//   busy          : high outside IDLE/ARMED
//   frame_count   : completed swaps (wraps)
//   timeout_err   : sticky rasterizer-timeout flag
module render_sequencer
    import gpu_pkg::*;
#(
    parameter int unsigned NUM_TRI         = 2,
    parameter int unsigned TRI_IDX_W       = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1,
    parameter int unsigned ZB_DEPTH        = ZB_DEPTH_DEFAULT,
    parameter int unsigned ZB_ADDR_W       = 17,
    parameter int unsigned ZB_DATA_W       = 6,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned RASTER_TIMEOUT  = 2000000
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 reset,
    input  logic                 user_key,
    input  logic                 continuous,
    input  logic                 vga_vs,
    input  logic                 raster_done,
    output logic                 raster_start,
    output logic [TRI_IDX_W-1:0] tri_idx,
    output logic                 zb_clr_we,
    output logic [ZB_ADDR_W-1:0] zb_clr_addr,
    output logic [ZB_DATA_W-1:0] zb_clr_data,
    output logic                 buffer_select,
    output logic                 busy,
    output logic [15:0]          frame_count,
    output logic                 timeout_err
);

    localparam int unsigned          TMO_W     = $clog2(RASTER_TIMEOUT + 1);
    localparam logic [TRI_IDX_W-1:0] LAST_TRI  = TRI_IDX_W'(NUM_TRI - 1);
    localparam logic [ZB_ADDR_W-1:0] LAST_ADDR = ZB_ADDR_W'(ZB_DEPTH - 1);
    localparam logic [TMO_W-1:0]     LAST_WAIT = TMO_W'(RASTER_TIMEOUT - 1);

    seq_state_t           r_state,       w_state_next;
    logic [TRI_IDX_W-1:0] r_tri_idx,     w_tri_idx_next;
    logic [ZB_ADDR_W-1:0] r_clr_addr,    w_clr_addr_next;
    logic [TMO_W-1:0]     r_wait_cnt,    w_wait_cnt_next;
    logic                 r_timeout_err, w_timeout_next;
    logic                 r_buf_sel,     w_buf_sel_next;
    logic [15:0]          r_frame_cnt,   w_frame_cnt_next;
    logic                 r_vs_prev;
    logic                 r_raster_start;
    logic                 r_zb_clr_we;
    logic                 r_busy;

    logic w_key_enable;
    logic w_trigger;
    logic w_reject;
    logic w_vs_fall;

    // The debouncer only runs in IDLE/ARMED, so the key is ignored while busy.
    assign w_key_enable = (r_state == ST_IDLE) || (r_state == ST_ARMED);
    assign w_vs_fall    = r_vs_prev && !vga_vs;

    key_debouncer #(
        .HOLD_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debouncer (
        .i_clk     (MAX10_CLK1_50),
        .i_reset   (reset),
        .i_enable  (w_key_enable),
        .i_key     (user_key),
        .o_trigger (w_trigger),
        .o_reject  (w_reject)
    );

    // Next-state and next-datapath logic for the frame sequencer.
    always_comb begin
        w_state_next     = r_state;
        w_tri_idx_next   = r_tri_idx;
        w_clr_addr_next  = r_clr_addr;
        w_wait_cnt_next  = {TMO_W{1'b0}};
        w_timeout_next   = r_timeout_err;
        w_buf_sel_next   = r_buf_sel;
        w_frame_cnt_next = r_frame_cnt;
        case (r_state)
            ST_IDLE: begin
                if (user_key) begin
                    w_state_next = ST_ARMED;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (w_trigger) begin
                    w_state_next    = ST_CLEAR;
                    w_tri_idx_next  = {TRI_IDX_W{1'b0}};
                    w_clr_addr_next = {ZB_ADDR_W{1'b0}};
                end else if (w_reject) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_ARMED;
                end
            end
            ST_CLEAR: begin
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_next    = ST_SETUP;
                    w_clr_addr_next = {ZB_ADDR_W{1'b0}};
                end else begin
                    w_clr_addr_next = r_clr_addr + ZB_ADDR_W'(1);
                end
            end
            ST_SETUP: w_state_next = ST_START;
            ST_START: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (raster_done) begin
                    w_state_next = ST_NEXT;
                end else if (r_wait_cnt == LAST_WAIT) begin
                    w_state_next   = ST_NEXT;
                    w_timeout_next = 1'b1;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + TMO_W'(1);
                end
            end
            ST_NEXT: begin
                if (r_tri_idx == LAST_TRI) begin
                    w_state_next = ST_SWAP;
                end else begin
                    w_tri_idx_next = r_tri_idx + TRI_IDX_W'(1);
                    w_state_next   = ST_SETUP;
                end
            end
            ST_SWAP: begin
                // Only a real high-to-low transition swaps, so entering with
                // vsync already low waits for the next frame's edge.
                if (w_vs_fall) begin
                    w_buf_sel_next   = !r_buf_sel;
                    w_frame_cnt_next = r_frame_cnt + 16'd1;
                    if (continuous) begin
                        w_state_next    = ST_CLEAR;
                        w_tri_idx_next  = {TRI_IDX_W{1'b0}};
                        w_clr_addr_next = {ZB_ADDR_W{1'b0}};
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_state_next = ST_SWAP;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State/datapath registers; strobes are decoded from the next state so
    // they are registered yet aligned with the state they belong to.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_tri_idx      <= {TRI_IDX_W{1'b0}};
            r_clr_addr     <= {ZB_ADDR_W{1'b0}};
            r_wait_cnt     <= {TMO_W{1'b0}};
            r_timeout_err  <= 1'b0;
            r_buf_sel      <= 1'b0;
            r_frame_cnt    <= 16'd0;
            r_vs_prev      <= 1'b1;
            r_raster_start <= 1'b0;
            r_zb_clr_we    <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_tri_idx      <= w_tri_idx_next;
            r_clr_addr     <= w_clr_addr_next;
            r_wait_cnt     <= w_wait_cnt_next;
            r_timeout_err  <= w_timeout_next;
            r_buf_sel      <= w_buf_sel_next;
            r_frame_cnt    <= w_frame_cnt_next;
            r_vs_prev      <= vga_vs;
            r_raster_start <= (w_state_next == ST_START);
            r_zb_clr_we    <= (w_state_next == ST_CLEAR);
            r_busy         <= is_busy_state(w_state_next);
        end
    end

    assign raster_start  = r_raster_start;
    assign tri_idx       = r_tri_idx;
    assign zb_clr_we     = r_zb_clr_we;
    assign zb_clr_addr   = r_clr_addr;
    assign zb_clr_data   = ZB_CLEAR_VALUE[ZB_DATA_W-1:0];
    assign buffer_select = r_buf_sel;
    assign busy          = r_busy;
    assign frame_count   = r_frame_cnt;
    assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_render_sequencer.sv
// Self-checking bench for render_sequencer: random key holds, rasterizer
// latencies and vsync periods, checked against frame-level expectations.
module tb_render_sequencer;

    localparam int NUM_TRI   = 3;
    localparam int TRI_IDX_W = 2;
    localparam int ZB_DEPTH  = 16;
    localparam int ZB_ADDR_W = 17;
    localparam int ZB_DATA_W = 6;
    localparam int DEB       = 4;
    localparam int TMO       = 50;

    logic                 clk        = 1'b0;
    logic                 reset      = 1'b1;
    logic                 user_key   = 1'b0;
    logic                 continuous = 1'b0;
    logic                 vs_hold    = 1'b0;
    logic                 vga_vs;
    logic                 raster_done;
    logic                 raster_start;
    logic [TRI_IDX_W-1:0] tri_idx;
    logic                 zb_clr_we;
    logic [ZB_ADDR_W-1:0] zb_clr_addr;
    logic [ZB_DATA_W-1:0] zb_clr_data;
    logic                 buffer_select;
    logic                 busy;
    logic [15:0]          frame_count;
    logic                 timeout_err;

    int tests = 0;
    int fails = 0;

    int lat_cfg   = 10;
    int hang_idx  = -1;
    int vs_period = 40;
    int vs_low    = 4;
    int vs_cnt    = 0;
    int rd_cnt    = 0;
    int cyc       = 0;
    int clr_bad   = 0;
    int busy_cnt  = 0;
    int clr_q[$];
    int st_idx_q[$];
    int st_cyc_q[$];

    int   clr_base, st_base, bad_base, busy_base;
    int   exp_frames = 0;
    logic exp_buf    = 1'b0;

    render_sequencer #(
        .NUM_TRI         (NUM_TRI),
        .TRI_IDX_W       (TRI_IDX_W),
        .ZB_DEPTH        (ZB_DEPTH),
        .ZB_ADDR_W       (ZB_ADDR_W),
        .ZB_DATA_W       (ZB_DATA_W),
        .DEBOUNCE_CYCLES (DEB),
        .RASTER_TIMEOUT  (TMO)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .reset         (reset),
        .user_key      (user_key),
        .continuous    (continuous),
        .vga_vs        (vga_vs),
        .raster_done   (raster_done),
        .raster_start  (raster_start),
        .tri_idx       (tri_idx),
        .zb_clr_we     (zb_clr_we),
        .zb_clr_addr   (zb_clr_addr),
        .zb_clr_data   (zb_clr_data),
        .buffer_select (buffer_select),
        .busy          (busy),
        .frame_count   (frame_count),
        .timeout_err   (timeout_err)
    );

    always #5 clk = ~clk;

    // Free-running vsync: low for vs_low cycles at the start of each period.
    always @(posedge clk) vs_cnt <= (vs_cnt >= vs_period - 1) ? 0 : vs_cnt + 1;
    assign vga_vs = vs_hold ? 1'b0 : (vs_cnt >= vs_low);

    // Rasterizer model: done level rises lat_cfg cycles after a start; never for hang_idx.
    always @(posedge clk) begin
        if (reset) begin
            raster_done <= 1'b0;
            rd_cnt      <= 0;
        end else if (raster_start === 1'b1) begin
            raster_done <= 1'b0;
            rd_cnt      <= (int'(tri_idx) == hang_idx) ? 0 : lat_cfg;
        end else if (rd_cnt == 1) begin
            raster_done <= 1'b1;
            rd_cnt      <= 0;
        end else if (rd_cnt > 1) begin
            rd_cnt <= rd_cnt - 1;
        end
    end

    // Event recorder: clear writes, start pulses (with cycle stamp), busy cycles.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            if (zb_clr_we === 1'b1) begin
                clr_q.push_back(int'(zb_clr_addr));
                if (zb_clr_data !== 6'h3F) clr_bad <= clr_bad + 1;
            end
            if (raster_start === 1'b1) begin
                st_idx_q.push_back(int'(tri_idx));
                st_cyc_q.push_back(cyc);
            end
            if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        clr_base  = clr_q.size();
        st_base   = st_idx_q.size();
        bad_base  = clr_bad;
        busy_base = busy_cnt;
    endtask

    task automatic press(input int n);
        user_key = 1'b1;
        repeat (n) @(negedge clk);
        user_key = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_buffer_select"}, buffer_select, 0);
        check({tag, "_tri_idx"},       tri_idx, 0);
        check({tag, "_raster_start"},  raster_start, 0);
        check({tag, "_zb_clr_we"},     zb_clr_we, 0);
        check({tag, "_zb_clr_addr"},   zb_clr_addr, 0);
        check({tag, "_zb_clr_data"},   zb_clr_data, 63);
        check({tag, "_busy"},          busy, 0);
        check({tag, "_frame_count"},   frame_count, 0);
        check({tag, "_timeout_err"},   timeout_err, 0);
    endtask

    // Wait (bounded) for the next swap and check it lands on a vsync fall.
    task automatic wait_frame();
        logic h1, h2;
        bit   seen;
        seen = 1'b0;
        h1   = vga_vs;
        h2   = vga_vs;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (frame_count != 16'(exp_frames)) begin
                seen = 1'b1;
            end else begin
                h2 = h1;
                h1 = vga_vs;
            end
        end
        check("frame_done", seen, 1);
        if (seen) begin
            exp_frames++;
            exp_buf = ~exp_buf;
            check("frame_count", frame_count, exp_frames & 16'hFFFF);
            check("buffer_select", buffer_select, exp_buf);
            check("swap_on_vs_fall", {h2, h1}, 2'b10);
        end
    endtask

    // One frame: full clear 0..DEPTH-1 of all-ones, then starts 0..N-1 spaced
    // by SETUP+START+NEXT plus the rasterizer latency (or the timeout).
    task automatic check_frame(input int lat, input int hang);
        int n, mism;
        n = clr_q.size() - clr_base;
        check("clr_count", n, ZB_DEPTH);
        mism = 0;
        for (int i = 0; i < n; i++) if (clr_q[clr_base + i] != i) mism++;
        check("clr_addr_seq", mism, 0);
        check("clr_data", clr_bad - bad_base, 0);
        n = st_idx_q.size() - st_base;
        check("start_count", n, NUM_TRI);
        for (int i = 0; i < n && i < NUM_TRI; i++) begin
            check("start_tri_idx", st_idx_q[st_base + i], i);
            if (i > 0)
                check("start_gap", st_cyc_q[st_base + i] - st_cyc_q[st_base + i - 1],
                      (hang == i - 1) ? TMO + 3 : lat + 4);
        end
    endtask

    initial begin
        int lat, n;
        repeat (3) @(negedge clk);
        check_reset("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // Short key hold is rejected.
        snap();
        press($urandom_range(1, 2));
        repeat (12) @(negedge clk);
        check("short_busy_cycles", busy_cnt - busy_base, 0);
        check("short_clr_writes", clr_q.size() - clr_base, 0);
        check("short_busy", busy, 0);

        // Single frame.
        vs_period = $urandom_range(30, 70);
        vs_low    = $urandom_range(2, 6);
        lat = $urandom_range(1, 20);
        lat_cfg = lat;
        snap();
        press($urandom_range(5, 8));
        wait_frame();
        check_frame(lat, -1);
        repeat (3) @(negedge clk);
        check("single_idle", busy, 0);
        check("single_no_timeout", timeout_err, 0);

        // Continuous mode, dropped during the third frame.
        continuous = 1'b1;
        lat = $urandom_range(1, 20);
        lat_cfg = lat;
        snap();
        press(5);
        for (int f = 0; f < 3; f++) begin
            wait_frame();
            check_frame(lat, -1);
            snap();
            lat = $urandom_range(1, 20);
            lat_cfg = lat;
            if (f == 1) continuous = 1'b0;
        end
        repeat (150) @(negedge clk);
        check("cont_stopped_fc", frame_count, exp_frames);
        check("cont_stopped_busy", busy, 0);
        check("cont_stopped_clr", clr_q.size() - clr_base, 0);

        // Rasterizer hang on triangle 1.
        hang_idx = 1;
        lat = $urandom_range(1, 20);
        lat_cfg = lat;
        snap();
        press(6);
        wait_frame();
        check_frame(lat, 1);
        check("timeout_err", timeout_err, 1);
        hang_idx = -1;

        // vsync already low on SWAP entry.
        lat = $urandom_range(1, 20);
        lat_cfg = lat;
        vs_hold = 1'b1;
        snap();
        press(5);
        for (int i = 0; i < 2000 && (st_idx_q.size() - st_base) < NUM_TRI; i++) @(negedge clk);
        repeat (lat + 40) @(negedge clk);
        check("hold_no_swap_fc", frame_count, exp_frames);
        check("hold_no_swap_buf", buffer_select, exp_buf);
        check("hold_still_busy", busy, 1);
        vs_hold = 1'b0;
        wait_frame();
        check_frame(lat, -1);
        repeat (150) @(negedge clk);
        check("hold_single_swap", frame_count, exp_frames);
        check("hold_idle", busy, 0);

        // Reset during CLEAR at address 7.
        press(5);
        n = 0;
        for (int i = 0; i < 200 && n == 0; i++) begin
            @(negedge clk);
            if (zb_clr_we === 1'b1 && zb_clr_addr === 17'd7) n = 1;
        end
        check("reached_clr_addr7", n, 1);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rst_clear");
        reset = 1'b0;
        exp_frames = 0;
        exp_buf = 1'b0;

        // Reset during WAIT, after one completed continuous frame.
        repeat (3) @(negedge clk);
        continuous = 1'b1;
        lat = $urandom_range(1, 20);
        lat_cfg = lat;
        snap();
        press(5);
        wait_frame();
        check_frame(lat, -1);
        n = 0;
        for (int i = 0; i < 200 && n == 0; i++) begin
            @(negedge clk);
            if (raster_start === 1'b1) n = 1;
        end
        check("reached_start", n, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset("rst_wait");
        reset = 1'b0;
        continuous = 1'b0;
        repeat (5) @(negedge clk);
        check("post_reset_busy", busy, 0);
        check("post_reset_fc", frame_count, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
